// File: rtl/uart_txbuf_if.sv
// rtl/uart_txbuf_if.sv - write-side and transmitter-side handshake bundle for uart_txbuf
interface uart_txbuf_if;
  logic [7:0] wrData;
  logic       wrEn;
  logic [7:0] txData;
  logic       txLoad;
  logic       txEmpty;
  logic       txIntr;

  modport master (
    output wrData, wrEn, txEmpty, txIntr,
    input  txData, txLoad
  );

  modport slave (
    input  wrData, wrEn, txEmpty, txIntr,
    output txData, txLoad
  );
endinterface

// File: rtl/uart_txbuf.sv
// rtl/uart_txbuf.sv - character FIFO feeding a UART transmitter with load/done handshake
module uart_txbuf #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ovflClr,
  uart_txbuf_if.slave            bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovfl,
  output logic                   idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAITBUSY = 2'd1,
    S_WAITDONE = 2'd2
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovfl;
  logic          r_txLoad;
  logic [7:0]    r_txData;
  state_t        r_state;
  state_t        w_state_nxt;

  logic w_clear;
  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_wr_drop;
  logic w_pop;

  // reset and clear are treated identically; either one wipes queue and handshake
  assign w_clear   = !rst || clr;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // acceptance is judged on registered occupancy, so a pop in the same cycle never rescues a full write
  assign w_wr_acc  = bus.wrEn && !w_full;
  assign w_wr_drop = bus.wrEn && w_full;

  // FSM state register
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state decode; stray encodings fall back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (!w_empty && bus.txEmpty)      w_state_nxt = S_WAITBUSY;
      S_WAITBUSY: if (!bus.txEmpty)                 w_state_nxt = S_WAITDONE;
      S_WAITDONE: if (bus.txIntr || bus.txEmpty)    w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: pop the head only when the transmitter is idle
  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE && !w_empty && bus.txEmpty) w_pop = 1'b1;
  end

  // registered load pulse and character towards the transmitter
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_txLoad <= 1'b0;
      r_txData <= 8'h00;
    end else begin
      r_txLoad <= w_pop;
      if (w_pop) r_txData <= r_mem[r_rptr];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // character storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_clear) r_mem[r_wptr] <= bus.wrData;
  end

  // sticky overflow; a drop in the same cycle as a clear request keeps it set
  always_ff @(posedge clk) begin
    if (w_clear)        r_ovfl <= 1'b0;
    else if (w_wr_drop) r_ovfl <= 1'b1;
    else if (ovflClr)   r_ovfl <= 1'b0;
  end

  assign count       = r_count;
  assign full        = w_full;
  assign ovfl        = r_ovfl;
  assign idle        = w_empty && (r_state == S_IDLE) && bus.txEmpty;
  assign bus.txData  = r_txData;
  assign bus.txLoad  = r_txLoad;

endmodule

// File: tb/tb_uart_txbuf.sv
// tb/tb_uart_txbuf.sv - scoreboard bench for uart_txbuf
module tb_uart_txbuf;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       ovflClr;
  logic [2:0] count;
  logic       full;
  logic       ovfl;
  logic       idle;

  logic       auto_tx;
  logic       man_txEmpty;
  logic       man_txIntr;
  logic       m_txEmpty;
  logic       m_txIntr;
  logic       prev_load;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];

  uart_txbuf_if bus();

  assign bus.txEmpty = auto_tx ? m_txEmpty : man_txEmpty;
  assign bus.txIntr  = auto_tx ? m_txIntr  : man_txIntr;

  uart_txbuf #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .ovflClr (ovflClr),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .ovfl    (ovfl),
    .idle    (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    bus.wrData = d;
    bus.wrEn   = 1'b1;
    if (acc) exp_q.push_back(d);
    tick();
    bus.wrEn   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 1);
    chk("drain_count", count, 0);
  endtask

  // hand back to the transmitter model once the DUT has reached WAITDONE
  task automatic handover();
    man_txEmpty = 1'b0;
    tick();
    auto_tx = 1'b1;
  endtask

  task automatic reset_mid_char(input bit use_rst);
    auto_tx     = 1'b0;
    man_txEmpty = 1'b0;
    wr(8'hC0, 1); wr(8'hC1, 1); wr(8'hC2, 1); wr(8'hC3, 1);
    wr(8'hDD, 0);
    chk("rc_ovfl_set", ovfl, 1);
    man_txEmpty = 1'b1;
    tick();
    chk("rc_load", bus.txLoad, 1);
    chk("rc_count3", count, 3);
    tick();
    man_txEmpty = 1'b0;
    tick();
    if (use_rst) rst = 1'b0;
    else         clr = 1'b1;
    bus.wrData = 8'h77;
    bus.wrEn   = 1'b1;
    tick();
    rst = 1'b1;
    clr = 1'b0;
    bus.wrEn = 1'b0;
    exp_q.delete();
    chk("rc_count", count, 0);
    chk("rc_load0", bus.txLoad, 0);
    chk("rc_ovfl", ovfl, 0);
    chk("rc_full", full, 0);
    chk("rc_txdata", bus.txData, 8'h00);
    man_txEmpty = 1'b1;
    #1;
    chk("rc_idle", idle, 1);
    tick();
    chk("rc_noload", bus.txLoad, 0);
    chk("rc_count_after", count, 0);
    chk("rc_idle_after", idle, 1);
  endtask

  // transmitter model: latch a load, go busy, then signal done
  initial begin
    m_txEmpty = 1'b1;
    m_txIntr  = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_tx && bus.txLoad === 1'b1) begin
        @(posedge clk); #2;
        m_txEmpty = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        m_txIntr  = 1'b1;
        m_txEmpty = 1'b1;
        @(posedge clk); #2;
        m_txIntr  = 1'b0;
      end
    end
  end

  // monitor: every load must match the next expected character
  initial begin
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.txLoad === 1'b1) begin
        chk("load_pulse_width", prev_load, 0);
        chk("load_while_busy", bus.txEmpty, 1);
        if (exp_q.size() == 0) chk("load_expected", exp_q.size(), 1);
        else                   chk("load_data", bus.txData, exp_q.pop_front());
      end
      prev_load = bus.txLoad;
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; ovflClr = 1'b0;
    bus.wrData = 8'h00; bus.wrEn = 1'b0;
    auto_tx = 1'b0; man_txEmpty = 1'b1; man_txIntr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_load", bus.txLoad, 0);
    chk("rst_txdata", bus.txData, 8'h00);
    chk("rst_idle", idle, 1);

    // single character with manual transmitter handshake
    wr(8'h41, 1);
    chk("s_count1", count, 1);
    chk("s_load_e0", bus.txLoad, 0);
    tick();
    chk("s_load_e1", bus.txLoad, 1);
    chk("s_data", bus.txData, 8'h41);
    chk("s_count0", count, 0);
    tick();
    chk("s_load_e2", bus.txLoad, 0);
    man_txEmpty = 1'b0;
    repeat (10) tick();
    chk("s_busy_idle", idle, 0);
    chk("s_data_hold", bus.txData, 8'h41);
    man_txIntr = 1'b1;
    tick();
    man_txIntr = 1'b0;
    chk("s_idle_txbusy", idle, 0);
    man_txEmpty = 1'b1;
    #1;
    chk("s_idle", idle, 1);
    tick();

    // burst: fill while the transmitter is busy, then release the model
    man_txEmpty = 1'b0;
    wr(8'h01, 1); wr(8'h02, 1); wr(8'h03, 1); wr(8'h04, 1);
    chk("b_full", full, 1);
    chk("b_count", count, 4);
    auto_tx = 1'b1;
    wait_drain(300);
    chk("b_full_end", full, 0);

    // overflow and ovflClr priority
    auto_tx = 1'b0;
    man_txEmpty = 1'b0;
    wr(8'h11, 1); wr(8'h12, 1); wr(8'h13, 1); wr(8'h14, 1);
    wr(8'h55, 0);
    chk("o_ovfl", ovfl, 1);
    chk("o_count", count, 4);
    ovflClr = 1'b1;
    tick();
    ovflClr = 1'b0;
    chk("o_ovfl_clr", ovfl, 0);
    ovflClr = 1'b1;
    wr(8'h56, 0);
    ovflClr = 1'b0;
    chk("o_ovfl_wins", ovfl, 1);
    ovflClr = 1'b1;
    tick();
    ovflClr = 1'b0;
    chk("o_ovfl_clr2", ovfl, 0);
    auto_tx = 1'b1;
    wait_drain(300);

    // boundary: full plus pop drops the write
    auto_tx = 1'b0;
    man_txEmpty = 1'b0;
    wr(8'hA0, 1); wr(8'hA1, 1); wr(8'hA2, 1); wr(8'hA3, 1);
    man_txEmpty = 1'b1;
    wr(8'hEE, 0);
    chk("bd_count3", count, 3);
    chk("bd_ovfl", ovfl, 1);
    chk("bd_load", bus.txLoad, 1);
    tick();
    handover();
    ovflClr = 1'b1;
    tick();
    ovflClr = 1'b0;
    wait_drain(300);

    // boundary: count 2 with write and pop stays 2
    auto_tx = 1'b0;
    man_txEmpty = 1'b0;
    wr(8'hB0, 1); wr(8'hB1, 1);
    man_txEmpty = 1'b1;
    wr(8'hB2, 1);
    chk("bd2_count", count, 2);
    chk("bd2_ovfl", ovfl, 0);
    tick();
    handover();
    wait_drain(300);

    // pointer wrap across ten characters
    auto_tx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int g = 0;
      while (full !== 1'b0 && g < 200) begin
        tick();
        g++;
      end
      wr(8'h30 + 8'(i), 1);
    end
    wait_drain(500);

    // clear then reset in the middle of a character
    reset_mid_char(1'b0);
    reset_mid_char(1'b1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
